// File: rtl/apb4_i2c_biu_if.sv
// APB4 slave bus plus the register-side req/ack port of the I2C bus interface unit.
// The slave modport is the BIU view; the master modport drives the APB side and answers the register side.
interface apb4_i2c_biu_if #(
  parameter int ADDR_WIDTH     = 5,
  parameter int APB_DATA_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 16
);
  localparam int STRB_W = APB_DATA_WIDTH / 8;

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]         pstrb;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  logic                      reg_req;
  logic                      reg_we;
  logic [ADDR_WIDTH-3:0]     reg_addr;
  logic [STRB_W-1:0]         reg_be;
  logic [APB_DATA_WIDTH-1:0] reg_wdata;
  logic                      reg_ack;
  logic [REG_DATA_WIDTH-1:0] reg_rdata;
  logic                      reg_err;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr,
    output reg_req, reg_we, reg_addr, reg_be, reg_wdata,
    input  reg_ack, reg_rdata, reg_err
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr,
    input  reg_req, reg_we, reg_addr, reg_be, reg_wdata,
    output reg_ack, reg_rdata, reg_err
  );
endinterface

// File: rtl/apb4_i2c_biu.sv
// APB4 to register req/ack bridge; pready two cycles after setup at best, one cycle for decode errors and no-op writes.
// Wait states are inserted while the register side withholds reg_ack, bounded by TIMEOUT (0 = unbounded).
module apb4_i2c_biu #(
  parameter int ADDR_WIDTH     = 5,
  parameter int APB_DATA_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 16,
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT        = 15
) (
  input logic           pclk,
  input logic           presetn,
  apb4_i2c_biu_if.slave bus
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = APB_DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      r_req, w_req_nxt;
  logic                      r_we, w_we_nxt;
  logic [IDX_W-1:0]          r_addr, w_addr_nxt;
  logic [STRB_W-1:0]         r_be, w_be_nxt;
  logic [APB_DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [APB_DATA_WIDTH-1:0] r_prdata, w_prdata_nxt;
  logic                      r_pready, w_pready_nxt;
  logic                      r_pslverr, w_pslverr_nxt;

  logic             w_setup;
  logic             w_bad_addr;
  logic             w_timeout;
  logic [IDX_W-1:0] w_idx;

  assign w_idx      = bus.paddr[ADDR_WIDTH-1:2];
  assign w_setup    = bus.psel & ~bus.penable;
  assign w_bad_addr = (bus.paddr[1:0] != 2'b00) || (32'(w_idx) >= NUM_REGS);
  assign w_timeout  = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_be      <= w_be_nxt;
      r_wdata   <= w_wdata_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_be_nxt      = r_be;
    w_wdata_nxt   = r_wdata;
    w_prdata_nxt  = '0;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_setup) begin
          w_we_nxt    = bus.pwrite;
          w_addr_nxt  = w_idx;
          w_wdata_nxt = bus.pwdata;
          w_be_nxt    = bus.pwrite ? bus.pstrb : '1;
          if (w_bad_addr) begin
            w_state_nxt   = RESP;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else if (bus.pwrite && (bus.pstrb == '0)) begin
            w_state_nxt  = RESP;
            w_pready_nxt = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_req_nxt   = 1'b1;
          end
        end
      end
      REQ: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (bus.reg_ack) begin
          w_state_nxt   = RESP;
          w_req_nxt     = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = bus.reg_err;
          w_prdata_nxt  = r_we ? '0 : APB_DATA_WIDTH'(bus.reg_rdata);
        end else if (w_timeout) begin
          w_state_nxt   = RESP;
          w_req_nxt     = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
        end else if (!bus.psel) begin
          // Master abandoned the transfer: drop the request silently.
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.prdata    = r_prdata;
  assign bus.pready    = r_pready;
  assign bus.pslverr   = r_pslverr;
  assign bus.reg_req   = r_req;
  assign bus.reg_we    = r_we;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_be    = r_be;
  assign bus.reg_wdata = r_wdata;
endmodule

// File: tb/tb_apb4_i2c_biu.sv
// Bench for apb4_i2c_biu: two instances (8 and 6 registers) share one stimulus stream.
// A transaction-level model is compared every cycle; directed transfers pin literal results.
module tb_apb4_i2c_biu;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RW = 16;
  localparam int TO = 15;

  logic pclk = 1'b0;
  logic presetn = 1'b1;
  always #5 pclk = ~pclk;

  logic          s_psel = 0, s_penable = 0, s_pwrite = 0, s_ack = 0, s_err = 0;
  logic [AW-1:0] s_paddr = 0;
  logic [DW-1:0] s_pwdata = 0;
  logic [3:0]    s_pstrb = 0;
  logic [RW-1:0] s_rdata = 0;

  apb4_i2c_biu_if #(.ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .REG_DATA_WIDTH(RW)) bus_a ();
  apb4_i2c_biu_if #(.ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .REG_DATA_WIDTH(RW)) bus_b ();

  assign bus_a.psel = s_psel;     assign bus_b.psel = s_psel;
  assign bus_a.penable = s_penable; assign bus_b.penable = s_penable;
  assign bus_a.pwrite = s_pwrite; assign bus_b.pwrite = s_pwrite;
  assign bus_a.paddr = s_paddr;   assign bus_b.paddr = s_paddr;
  assign bus_a.pwdata = s_pwdata; assign bus_b.pwdata = s_pwdata;
  assign bus_a.pstrb = s_pstrb;   assign bus_b.pstrb = s_pstrb;
  assign bus_a.reg_ack = s_ack;   assign bus_b.reg_ack = s_ack;
  assign bus_a.reg_rdata = s_rdata; assign bus_b.reg_rdata = s_rdata;
  assign bus_a.reg_err = s_err;   assign bus_b.reg_err = s_err;

  apb4_i2c_biu #(.ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .REG_DATA_WIDTH(RW),
                 .NUM_REGS(8), .TIMEOUT(TO)) u_dut_a (.pclk(pclk), .presetn(presetn), .bus(bus_a));
  apb4_i2c_biu #(.ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .REG_DATA_WIDTH(RW),
                 .NUM_REGS(6), .TIMEOUT(TO)) u_dut_b (.pclk(pclk), .presetn(presetn), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: per instance, what the APB/register outputs must be, derived from transfer rules.
  int          nregs [2] = '{8, 6};
  logic        e_req [2] = '{0, 0};
  logic        e_pready [2] = '{0, 0};
  logic        e_pslverr [2] = '{0, 0};
  logic        e_we [2] = '{0, 0};
  logic [31:0] e_prdata [2] = '{0, 0};
  logic [31:0] e_wdata [2] = '{0, 0};
  logic [2:0]  e_addr [2] = '{0, 0};
  logic [3:0]  e_be [2] = '{0, 0};
  int          m_waited [2] = '{0, 0};

  always @(posedge pclk or negedge presetn) begin
    for (int n = 0; n < 2; n++) begin
      if (!presetn) begin
        e_req[n] <= 0; e_pready[n] <= 0; e_pslverr[n] <= 0; e_we[n] <= 0;
        e_prdata[n] <= 0; e_wdata[n] <= 0; e_addr[n] <= 0; e_be[n] <= 0; m_waited[n] <= 0;
      end else if (e_pready[n]) begin
        e_pready[n] <= 0; e_pslverr[n] <= 0; e_prdata[n] <= 0;
      end else if (e_req[n]) begin
        m_waited[n] <= m_waited[n] + 1;
        if (s_ack) begin
          e_req[n] <= 0; e_pready[n] <= 1; e_pslverr[n] <= s_err;
          e_prdata[n] <= e_we[n] ? 32'h0 : {16'h0, s_rdata};
        end else if (TO > 0 && m_waited[n] + 1 == TO) begin
          e_req[n] <= 0; e_pready[n] <= 1; e_pslverr[n] <= 1; e_prdata[n] <= 0;
        end else if (!s_psel) begin
          e_req[n] <= 0;
        end
      end else if (s_psel && !s_penable) begin
        e_we[n] <= s_pwrite; e_addr[n] <= s_paddr[4:2]; e_wdata[n] <= s_pwdata;
        e_be[n] <= s_pwrite ? s_pstrb : 4'hF;
        if (s_paddr[1:0] != 0 || int'(s_paddr[4:2]) >= nregs[n]) begin
          e_pready[n] <= 1; e_pslverr[n] <= 1;
        end else if (s_pwrite && s_pstrb == 0) begin
          e_pready[n] <= 1;
        end else begin
          e_req[n] <= 1; m_waited[n] <= 0;
        end
      end
    end
  end

  task automatic chk_inst(input int n, input logic [31:0] prd, input logic rdy, input logic err,
                          input logic req, input logic we, input logic [2:0] adr,
                          input logic [3:0] be, input logic [31:0] wd);
    string p;
    p = (n == 0) ? "a" : "b";
    chk({p, ".pready"}, rdy, e_pready[n]);
    chk({p, ".pslverr"}, err, e_pslverr[n]);
    chk({p, ".prdata"}, prd, e_prdata[n]);
    chk({p, ".reg_req"}, req, e_req[n]);
    chk({p, ".reg_we"}, we, e_we[n]);
    chk({p, ".reg_addr"}, adr, e_addr[n]);
    chk({p, ".reg_be"}, be, e_be[n]);
    chk({p, ".reg_wdata"}, wd, e_wdata[n]);
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      chk_inst(0, bus_a.prdata, bus_a.pready, bus_a.pslverr, bus_a.reg_req, bus_a.reg_we,
               bus_a.reg_addr, bus_a.reg_be, bus_a.reg_wdata);
      chk_inst(1, bus_b.prdata, bus_b.pready, bus_b.pslverr, bus_b.reg_req, bus_b.reg_we,
               bus_b.reg_addr, bus_b.reg_be, bus_b.reg_wdata);
    end
  end

  // Results of the last transfer, observed at each instance's pready cycle.
  int          r_lat_a, r_lat_b, r_reqn;
  logic [31:0] r_rd_a, r_rd_b, r_wd_a;
  logic        r_err_a, r_err_b;
  logic [2:0]  r_addr_a;
  logic [3:0]  r_be_a;

  // ack_at: REQ cycle (1-based) in which reg_ack is pulsed; 0 = never.
  task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input int ack_at, input logic rerr,
                     input logic [15:0] rd);
    @(negedge pclk);
    s_psel = 1; s_penable = 0; s_pwrite = wr; s_paddr = addr; s_pwdata = wd; s_pstrb = strb;
    r_lat_a = -1; r_lat_b = -1; r_reqn = 0;
    for (int c = 1; c <= 40 && r_lat_a < 0; c++) begin
      @(negedge pclk);
      s_penable = 1;
      if (bus_b.pready && r_lat_b < 0) begin
        r_lat_b = c; r_rd_b = bus_b.prdata; r_err_b = bus_b.pslverr;
      end
      if (bus_a.reg_req) r_reqn++;
      if (bus_a.pready) begin
        r_lat_a = c; r_rd_a = bus_a.prdata; r_err_a = bus_a.pslverr;
        r_addr_a = bus_a.reg_addr; r_be_a = bus_a.reg_be; r_wd_a = bus_a.reg_wdata;
      end
      s_ack = (c == ack_at);
      s_err = rerr & s_ack;
      s_rdata = s_ack ? rd : 16'h0;
    end
    s_psel = 0; s_penable = 0; s_ack = 0; s_err = 0; s_rdata = 0;
  endtask

  initial begin
    #1 presetn = 0;
    chk_en = 1;
    repeat (2) @(negedge pclk);
    chk("rst.pready", bus_a.pready, 0);
    chk("rst.reg_req", bus_a.reg_req, 0);
    chk("rst.prdata", bus_a.prdata, 0);
    chk("rst.reg_wdata", bus_a.reg_wdata, 0);
    presetn = 1;

    apb(1, 5'h08, 32'hA5A5_1234, 4'hF, 1, 0, 16'h0);
    chk("wr08.lat", r_lat_a, 2);
    chk("wr08.err", r_err_a, 0);
    chk("wr08.addr", r_addr_a, 2);
    chk("wr08.be", r_be_a, 4'hF);
    chk("wr08.wdata", r_wd_a, 32'hA5A5_1234);
    chk("wr08.reqn", r_reqn, 1);

    apb(0, 5'h1C, 32'h0, 4'h0, 3, 0, 16'hBEEF);
    chk("rd1c.lat", r_lat_a, 4);
    chk("rd1c.prdata", r_rd_a, 32'h0000_BEEF);
    chk("rd1c.err", r_err_a, 0);
    chk("rd1c.be", r_be_a, 4'hF);
    chk("rd1c.b_lat", r_lat_b, 1);
    chk("rd1c.b_err", r_err_b, 1);

    apb(0, 5'h06, 32'h0, 4'hF, 0, 0, 16'h0);
    chk("rd06.lat", r_lat_a, 1);
    chk("rd06.err", r_err_a, 1);
    chk("rd06.reqn", r_reqn, 0);

    apb(0, 5'h18, 32'h0, 4'hF, 1, 0, 16'h1234);
    chk("rd18.lat", r_lat_a, 2);
    chk("rd18.prdata", r_rd_a, 32'h0000_1234);
    chk("rd18.b_lat", r_lat_b, 1);
    chk("rd18.b_err", r_err_b, 1);
    chk("rd18.b_prdata", r_rd_b, 0);

    apb(1, 5'h04, 32'h1111_2222, 4'h0, 0, 0, 16'h0);
    chk("wr04z.lat", r_lat_a, 1);
    chk("wr04z.err", r_err_a, 0);
    chk("wr04z.reqn", r_reqn, 0);

    apb(1, 5'h04, 32'h3333_4444, 4'h5, 1, 0, 16'h0);
    chk("wr04p.lat", r_lat_a, 2);
    chk("wr04p.be", r_be_a, 4'h5);

    apb(0, 5'h00, 32'h0, 4'hF, 0, 0, 16'h0);
    chk("tmo.lat", r_lat_a, TO + 1);
    chk("tmo.reqn", r_reqn, TO);
    chk("tmo.err", r_err_a, 1);
    chk("tmo.prdata", r_rd_a, 0);

    apb(1, 5'h0C, 32'hDEAD_0000, 4'hC, 2, 1, 16'h0);
    chk("regerr.lat", r_lat_a, 3);
    chk("regerr.err", r_err_a, 1);

    // Master drops psel in the middle of a wait: request withdrawn, no response.
    @(negedge pclk);
    s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 5'h08; s_pstrb = 4'hF;
    @(negedge pclk);
    s_penable = 1;
    @(negedge pclk);
    chk("abort.req_before", bus_a.reg_req, 1);
    s_psel = 0; s_penable = 0;
    @(negedge pclk);
    chk("abort.req_after", bus_a.reg_req, 0);
    chk("abort.pready", bus_a.pready, 0);

    // Reset asserted while a request is outstanding.
    @(negedge pclk);
    s_psel = 1; s_penable = 0; s_pwrite = 1; s_paddr = 5'h10; s_pwdata = 32'hCAFE_F00D; s_pstrb = 4'hF;
    @(negedge pclk);
    s_penable = 1;
    @(negedge pclk);
    chk("rstreq.req_before", bus_a.reg_req, 1);
    #2 presetn = 0;
    #1;
    chk("rstreq.req", bus_a.reg_req, 0);
    chk("rstreq.b_req", bus_b.reg_req, 0);
    chk("rstreq.wdata", bus_a.reg_wdata, 0);
    chk("rstreq.be", bus_a.reg_be, 0);
    chk("rstreq.we", bus_a.reg_we, 0);
    @(negedge pclk);
    s_psel = 0; s_penable = 0;
    presetn = 1;

    apb(1, 5'h10, 32'hCAFE_F00D, 4'hF, 1, 0, 16'h0);
    chk("postrst.lat", r_lat_a, 2);
    chk("postrst.err", r_err_a, 0);
    chk("postrst.addr", r_addr_a, 4);
    chk("postrst.wdata", r_wd_a, 32'hCAFE_F00D);

    repeat (3) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
